// File: rtl/tns_decoder_09_pkg.sv
// Shared TNS definitions: code/data widths, digit weights and the per-bit weight lookup
// used by both the encoder and tns_decoder_09.
package tns_decoder_09_pkg;

    localparam int TNS_CODE_W = 9;
    localparam int TNS_DATA_W = 7;

    typedef logic [TNS_CODE_W-1:0] tns_code_t;
    typedef logic [TNS_DATA_W-1:0] tns_data_t;

    typedef struct packed {
        logic      vld;
        tns_code_t code;
    } tns_word_t;

    localparam tns_data_t TNS01_A = 7'd2;
    localparam tns_data_t TNS01_B = 7'd1;
    localparam tns_data_t TNS02_A = 7'd8;
    localparam tns_data_t TNS02_B = 7'd5;
    localparam tns_data_t TNS02_C = 7'd3;
    localparam tns_data_t TNS03_A = 7'd34;
    localparam tns_data_t TNS03_B = 7'd21;
    localparam tns_data_t TNS03_C = 7'd13;

    // Bit 0 is the plain LSB; the remaining bits follow the three TNS digit groups.
    function automatic tns_data_t tns_weight(input int unsigned idx);
        tns_data_t w;
        case (idx)
            0:       w = 7'd1;
            1:       w = TNS01_B;
            2:       w = TNS01_A;
            3:       w = TNS02_C;
            4:       w = TNS02_B;
            5:       w = TNS02_A;
            6:       w = TNS03_C;
            7:       w = TNS03_B;
            8:       w = TNS03_A;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tns_decoder_09_if.sv
// Codeword-in / value-out bus of tns_decoder_09; the crosstalk status signals
// exist only when TNS_DEC_XTALK_CHK_EN is defined.
interface tns_decoder_09_if
    import tns_decoder_09_pkg::*;
#(
    parameter int ERR_CNT_W = 8
);
    tns_code_t code_in;
    logic      code_vld_in;
    tns_data_t data_out;
    logic      data_vld_out;

    if (ERR_CNT_W < 1) begin : g_bad_err_cnt_w
        $error("ERR_CNT_W must be at least 1");
    end

`ifdef TNS_DEC_XTALK_CHK_EN
    logic                 xtalk_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output code_in, code_vld_in,
        input  data_out, data_vld_out, xtalk_err, err_cnt
    );

    modport slave (
        input  code_in, code_vld_in,
        output data_out, data_vld_out, xtalk_err, err_cnt
    );
`else
    modport master (
        output code_in, code_vld_in,
        input  data_out, data_vld_out
    );

    modport slave (
        input  code_in, code_vld_in,
        output data_out, data_vld_out
    );
`endif

endinterface

// File: rtl/tns_xtalk_chk.sv
// Opposite-transition crosstalk checker: compares each stage-1 codeword against the
// last valid one and reports violations one cycle later, aligned with the decoded output.
module tns_xtalk_chk
    import tns_decoder_09_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  tns_code_t            cur_code,
    input  logic                 cur_vld,
    output logic                 xtalk_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    tns_code_t            prev_reg;
    logic                 have_prev_reg;
    logic                 xtalk_reg;
    logic [ERR_CNT_W-1:0] cnt_reg;
    logic [TNS_CODE_W-2:0] viol_bits;
    logic                 hit_next;

    // Adjacent wires that both toggle and end up at opposite levels moved in opposite directions.
    for (genvar gi = 0; gi < TNS_CODE_W - 1; gi++) begin : g_pair
        assign viol_bits[gi] = (prev_reg[gi]   ^ cur_code[gi])
                             & (prev_reg[gi+1] ^ cur_code[gi+1])
                             & (cur_code[gi]   ^ cur_code[gi+1]);
    end

    assign hit_next = cur_vld & have_prev_reg & (|viol_bits);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg      <= '0;
            have_prev_reg <= 1'b0;
            xtalk_reg     <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            xtalk_reg <= hit_next;
            if (cur_vld) begin
                prev_reg      <= cur_code;
                have_prev_reg <= 1'b1;
            end
            if (hit_next && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign xtalk_err = xtalk_reg;
    assign err_cnt   = cnt_reg;

endmodule

// File: rtl/tns_decoder_09.sv
// Two-stage TNS codeword decoder (weighted bit sum, 0..88). Defining TNS_DEC_XTALK_CHK_EN
// adds the crosstalk checker and its xtalk_err/err_cnt outputs on the bus.
module tns_decoder_09
    import tns_decoder_09_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    tns_decoder_09_if.slave   bus
);

    if (ERR_CNT_W < 1) begin : g_bad_err_cnt_w
        $error("ERR_CNT_W must be at least 1");
    end

    tns_word_t s1_reg;
    tns_data_t data_reg;
    logic      vld2_reg;
    tns_data_t sum_next;
    tns_data_t term [TNS_CODE_W];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= '0;
        end else begin
            s1_reg.vld <= bus.code_vld_in;
            if (bus.code_vld_in) begin
                s1_reg.code <= bus.code_in;
            end
        end
    end

    for (genvar gi = 0; gi < TNS_CODE_W; gi++) begin : g_term
        localparam tns_data_t W = tns_weight(gi);
        assign term[gi] = s1_reg.code[gi] ? W : '0;
    end

    // Largest possible total is 88, so the 7-bit accumulator never wraps.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < TNS_CODE_W; i++) begin
            sum_next = sum_next + term[i];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            vld2_reg <= 1'b0;
        end else begin
            vld2_reg <= s1_reg.vld;
            if (s1_reg.vld) begin
                data_reg <= sum_next;
            end
        end
    end

    assign bus.data_out     = data_reg;
    assign bus.data_vld_out = vld2_reg;

`ifdef TNS_DEC_XTALK_CHK_EN
    tns_xtalk_chk #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_xtalk_chk (
        .clock     (clock),
        .rst_n     (rst_n),
        .cur_code  (s1_reg.code),
        .cur_vld   (s1_reg.vld),
        .xtalk_err (bus.xtalk_err),
        .err_cnt   (bus.err_cnt)
    );
`endif

endmodule
